// File: rtl/vending_sequencer_if.sv
// Bundle between the vending sequencer, the front panel / coin acceptor and the
// product_selector datapath. The slave modport is the sequencer's view; the master
// modport is the surrounding environment's view.
interface vending_sequencer_if #(
  parameter int unsigned CREDIT_W = 6
) ();

  // Front panel and coin acceptor
  logic                product_req;
  logic [1:0]          product_code;
  logic                coin_valid;
  logic [4:0]          coin_value;
  logic                cancel;

  // product_selector handshake
  logic                ps_signal;
  logic [1:0]          ps_sel;
  logic [4:0]          ps_price;
  logic                ps_selector_done;
  logic                ps_dispense_en;
  logic                ps_dispense_done;

  // Status and refund
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amount;
  logic                error;
  logic                busy;

  modport slave (
    input  product_req,
    input  product_code,
    input  coin_valid,
    input  coin_value,
    input  cancel,
    output ps_signal,
    output ps_sel,
    input  ps_price,
    input  ps_selector_done,
    output ps_dispense_en,
    input  ps_dispense_done,
    output credit,
    output coin_reject,
    output change_valid,
    output change_amount,
    output error,
    output busy
  );

  modport master (
    output product_req,
    output product_code,
    output coin_valid,
    output coin_value,
    output cancel,
    input  ps_signal,
    input  ps_sel,
    output ps_price,
    output ps_selector_done,
    input  ps_dispense_en,
    output ps_dispense_done,
    input  credit,
    input  coin_reject,
    input  change_valid,
    input  change_amount,
    input  error,
    input  busy
  );

endinterface

// File: rtl/vending_sequencer.sv
// Vending transaction controller: takes a product request and coins, asks the
// product_selector for the price, collects credit, triggers dispensing and pays out
// change on completion, cancel, payment timeout or fault. All outputs are registered.
module vending_sequencer #(
  parameter int unsigned CREDIT_W    = 6,
  parameter int unsigned SEL_TIMEOUT = 8,
  parameter int unsigned PAY_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  vending_sequencer_if.slave vend_io
);

  localparam int unsigned MaxTimeout = (PAY_TIMEOUT > SEL_TIMEOUT) ? PAY_TIMEOUT : SEL_TIMEOUT;
  localparam int unsigned TimerW     = $clog2(MaxTimeout + 1);
  // Timer value on the last permitted cycle; the following edge takes the timeout path.
  localparam logic [TimerW-1:0] SelLast = TimerW'(SEL_TIMEOUT - 1);
  localparam logic [TimerW-1:0] PayLast = TimerW'(PAY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StWaitSel,
    StPay,
    StDispense,
    StWaitDisp,
    StChange
  } state_e;

  state_e              state_q;
  logic [1:0]          code_q;
  logic [4:0]          price_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [TimerW-1:0]   timer_q;
  logic                ps_signal_q;
  logic                dispense_en_q;
  logic                coin_reject_q;
  logic                change_valid_q;
  logic [CREDIT_W-1:0] change_amount_q;
  logic                error_q;
  logic                busy_q;

  logic                coin_present;
  logic                coin_open;
  logic                coin_fits;
  logic [CREDIT_W:0]   coin_sum;
  logic                credit_covers;

  // Coin arithmetic: one extra bit on the sum flags an overflowing insert.
  always_comb begin
    coin_present  = vend_io.coin_valid && (vend_io.coin_value != '0);
    coin_open     = (state_q == StIdle) || (state_q == StPay);
    coin_sum      = {1'b0, credit_q} + (CREDIT_W + 1)'(vend_io.coin_value);
    coin_fits     = !coin_sum[CREDIT_W];
    credit_covers = credit_q >= CREDIT_W'(price_q);
  end

  // Transaction FSM with registered outputs; pulse outputs default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      code_q          <= '0;
      price_q         <= '0;
      credit_q        <= '0;
      timer_q         <= '0;
      ps_signal_q     <= 1'b0;
      dispense_en_q   <= 1'b0;
      coin_reject_q   <= 1'b0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      error_q         <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      ps_signal_q    <= 1'b0;
      dispense_en_q  <= 1'b0;
      coin_reject_q  <= 1'b0;
      change_valid_q <= 1'b0;
      error_q        <= 1'b0;

      // Coins are credited before any state decision, so a coin arriving together
      // with cancel in PAY ends up in the refund.
      if (coin_present) begin
        if (coin_open && coin_fits) begin
          credit_q <= coin_sum[CREDIT_W-1:0];
        end else begin
          coin_reject_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (vend_io.product_req) begin
            code_q      <= vend_io.product_code;
            ps_signal_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StSelect;
          end else if (vend_io.cancel && (credit_q != '0)) begin
            busy_q  <= 1'b1;
            state_q <= StChange;
          end
        end

        StSelect: begin
          timer_q <= '0;
          state_q <= StWaitSel;
        end

        StWaitSel: begin
          if (vend_io.ps_selector_done) begin
            price_q <= vend_io.ps_price;
            if (vend_io.ps_price == '0) begin
              // Zero price marks an invalid product code.
              error_q <= 1'b1;
              state_q <= StChange;
            end else begin
              timer_q <= '0;
              state_q <= StPay;
            end
          end else if (timer_q == SelLast) begin
            error_q <= 1'b1;
            state_q <= StChange;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StPay: begin
          // Compared against registered credit: a coin is seen here one cycle later.
          if (credit_covers) begin
            dispense_en_q <= 1'b1;
            state_q       <= StDispense;
          end else if (vend_io.cancel) begin
            state_q <= StChange;
          end else if (coin_present) begin
            timer_q <= '0;
          end else if (timer_q == PayLast) begin
            state_q <= StChange;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StDispense: begin
          timer_q <= '0;
          state_q <= StWaitDisp;
        end

        StWaitDisp: begin
          // Cancel is ignored once the product is being dispensed.
          if (vend_io.ps_dispense_done) begin
            credit_q <= credit_q - CREDIT_W'(price_q);
            state_q  <= StChange;
          end else if (timer_q == SelLast) begin
            error_q <= 1'b1;
            state_q <= StChange;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StChange: begin
          change_valid_q  <= 1'b1;
          change_amount_q <= credit_q;
          credit_q        <= '0;
          busy_q          <= 1'b0;
          state_q         <= StIdle;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign vend_io.ps_signal      = ps_signal_q;
  assign vend_io.ps_sel         = code_q;
  assign vend_io.ps_dispense_en = dispense_en_q;
  assign vend_io.credit         = credit_q;
  assign vend_io.coin_reject    = coin_reject_q;
  assign vend_io.change_valid   = change_valid_q;
  assign vend_io.change_amount  = change_amount_q;
  assign vend_io.error          = error_q;
  assign vend_io.busy           = busy_q;

endmodule

// File: tb/tb_vending_sequencer.sv
// Scoreboard bench for vending_sequencer: stimulus pushes the expected pulse events,
// a negedge monitor pops and compares each observed pulse in order.
module tb_vending_sequencer;

  localparam int unsigned CreditW = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vending_sequencer_if #(.CREDIT_W(CreditW)) vif ();

  vending_sequencer #(
    .CREDIT_W   (CreditW),
    .SEL_TIMEOUT(8),
    .PAY_TIMEOUT(255)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .vend_io(vif)
  );

  typedef enum int {EvSig, EvDisp, EvErr, EvChg, EvRej} ev_e;
  typedef struct {
    ev_e kind;
    int  val;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  function automatic void check(string name, int act, int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  function automatic void expect_ev(ev_e kind, int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endfunction

  function automatic void observe(ev_e kind, int val);
    ev_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected event: got %s/%0d, expected none", kind.name(), val);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind == kind && e.val == val) n_pass++;
    else $display("FAIL event order: got %s/%0d, expected %s/%0d",
                  kind.name(), val, e.kind.name(), e.val);
  endfunction

  // Monitor: fixed per-cycle order sig, disp, err, chg, rej.
  always @(negedge clk) begin
    if (!rst) begin
      if (vif.ps_signal) observe(EvSig, int'(vif.ps_sel));
      if (vif.ps_dispense_en) observe(EvDisp, 0);
      if (vif.ps_signal || vif.ps_dispense_en)
        check("sig_disp_exclusive", int'(vif.ps_signal && vif.ps_dispense_en), 0);
      if (vif.error) observe(EvErr, 0);
      if (vif.change_valid) observe(EvChg, int'(vif.change_amount));
      if (vif.coin_reject) observe(EvRej, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request ends with the DUT in WAIT_SEL.
  task automatic req(input logic [1:0] code);
    expect_ev(EvSig, int'(code));
    vif.product_req  = 1'b1;
    vif.product_code = code;
    tick();
    vif.product_req = 1'b0;
    tick();
  endtask

  task automatic sel_done(input logic [4:0] price);
    vif.ps_price         = price;
    vif.ps_selector_done = 1'b1;
    tick();
    vif.ps_selector_done = 1'b0;
  endtask

  task automatic coin(input logic [4:0] v);
    vif.coin_valid = 1'b1;
    vif.coin_value = v;
    tick();
    vif.coin_valid = 1'b0;
    vif.coin_value = '0;
  endtask

  task automatic disp_done();
    vif.ps_dispense_done = 1'b1;
    tick();
    vif.ps_dispense_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                  = 1'b1;
    vif.product_req      = 1'b0;
    vif.product_code     = '0;
    vif.coin_valid       = 1'b0;
    vif.coin_value       = '0;
    vif.cancel           = 1'b0;
    vif.ps_price         = '0;
    vif.ps_selector_done = 1'b0;
    vif.ps_dispense_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_credit", int'(vif.credit), 0);
    check("rst_busy", int'(vif.busy), 0);
    check("rst_ps_sel", int'(vif.ps_sel), 0);
    check("rst_change_amount", int'(vif.change_amount), 0);
    check("rst_error", int'(vif.error), 0);

    // 1: code 01, price 10, coins 5+5, dispense, change 0
    req(2'b01);
    sel_done(5'd10);
    coin(5'd5);
    coin(5'd5);
    check("t1_credit", int'(vif.credit), 10);
    expect_ev(EvDisp, 0);
    tick();
    tick();
    expect_ev(EvChg, 0);
    disp_done();
    tick();
    tick();
    check("t1_busy_idle", int'(vif.busy), 0);

    // 2: coin 20 in IDLE, code 10 price 15, change 5
    coin(5'd20);
    check("t2_idle_credit", int'(vif.credit), 20);
    req(2'b10);
    sel_done(5'd15);
    expect_ev(EvDisp, 0);
    tick();
    tick();
    expect_ev(EvChg, 5);
    disp_done();
    tick();
    check("t2_change_amount", int'(vif.change_amount), 5);
    check("t2_credit", int'(vif.credit), 0);

    // 3: invalid code 00 -> error, refund prior credit
    coin(5'd7);
    req(2'b00);
    expect_ev(EvErr, 0);
    expect_ev(EvChg, 7);
    sel_done(5'd0);
    tick();
    check("t3_credit", int'(vif.credit), 0);

    // 4: overflow reject at 60, then coin during WAIT_DISP rejected
    coin(5'd31);
    coin(5'd29);
    check("t4_credit60", int'(vif.credit), 60);
    expect_ev(EvRej, 0);
    coin(5'd5);
    check("t4_reject_pulse", int'(vif.coin_reject), 1);
    check("t4_credit_held", int'(vif.credit), 60);
    req(2'b01);
    sel_done(5'd10);
    expect_ev(EvDisp, 0);
    tick();
    tick();
    expect_ev(EvRej, 0);
    coin(5'd3);
    check("t4_waitdisp_credit", int'(vif.credit), 60);
    expect_ev(EvChg, 50);
    disp_done();
    tick();
    check("t4_change_amount", int'(vif.change_amount), 50);

    // 5a: cancel in PAY refunds 4
    req(2'b01);
    sel_done(5'd10);
    coin(5'd4);
    expect_ev(EvChg, 4);
    vif.cancel = 1'b1;
    tick();
    vif.cancel = 1'b0;
    tick();
    check("t5_cancel_amount", int'(vif.change_amount), 4);

    // 5b: PAY timeout after 255 idle cycles, no error
    req(2'b01);
    sel_done(5'd10);
    expect_ev(EvChg, 0);
    repeat (255) tick();
    check("t5_no_early_timeout", int'(vif.change_valid), 0);
    tick();
    check("t5_timeout_refund", int'(vif.change_valid), 1);
    check("t5_timeout_amount", int'(vif.change_amount), 0);
    check("t5_no_error", int'(vif.error), 0);

    // 6a: selector never answers -> error after 8 cycles, refund 9
    coin(5'd9);
    req(2'b01);
    repeat (7) tick();
    check("t6_no_early_error", int'(vif.error), 0);
    expect_ev(EvErr, 0);
    expect_ev(EvChg, 9);
    tick();
    check("t6_error_pulse", int'(vif.error), 1);
    tick();

    // 6b: reset in PAY drops credit silently
    req(2'b10);
    sel_done(5'd20);
    coin(5'd6);
    check("t6_pay_credit", int'(vif.credit), 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_credit", int'(vif.credit), 0);
    check("t6_rst_busy", int'(vif.busy), 0);
    check("t6_rst_ps_sel", int'(vif.ps_sel), 0);
    check("t6_rst_change_amount", int'(vif.change_amount), 0);
    tick();
    coin(5'd3);
    check("t6_idle_after_rst", int'(vif.credit), 3);

    // 7: coin and cancel together in PAY -> refund includes coin
    req(2'b01);
    sel_done(5'd10);
    expect_ev(EvChg, 7);
    vif.coin_valid = 1'b1;
    vif.coin_value = 5'd4;
    vif.cancel     = 1'b1;
    tick();
    vif.coin_valid = 1'b0;
    vif.coin_value = '0;
    vif.cancel     = 1'b0;
    tick();
    check("t7_credit", int'(vif.credit), 0);

    // 8: coin with product_req in IDLE, credit exactly equals price
    expect_ev(EvSig, 3);
    vif.product_req  = 1'b1;
    vif.product_code = 2'b11;
    vif.coin_valid   = 1'b1;
    vif.coin_value   = 5'd12;
    tick();
    vif.product_req = 1'b0;
    vif.coin_valid  = 1'b0;
    vif.coin_value  = '0;
    tick();
    check("t8_credit", int'(vif.credit), 12);
    sel_done(5'd12);
    expect_ev(EvDisp, 0);
    tick();
    tick();
    expect_ev(EvChg, 0);
    disp_done();
    tick();
    tick();
    tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
